// File: rtl/apex_ctrl_pkg.sv
// Shared opcode/funct3 encodings and FSM state type for the multi-cycle control unit.
// No logic of its own: types, constants and two small decode helpers.
package apex_ctrl_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   // Load/store access width lives in funct3[1:0]; funct3[2] selects zero-extension.
   localparam logic [1:0] F3_B = 2'd0;
   localparam logic [1:0] F3_H = 2'd1;
   localparam logic [1:0] F3_W = 2'd2;
   localparam logic [1:0] F3_D = 2'd3;

   localparam logic [2:0] F3_BEQ  = 3'd0;
   localparam logic [2:0] F3_BNE  = 3'd1;
   localparam logic [2:0] F3_BLT  = 3'd4;
   localparam logic [2:0] F3_BGE  = 3'd5;
   localparam logic [2:0] F3_BLTU = 3'd6;
   localparam logic [2:0] F3_BGEU = 3'd7;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEM, S_WB} state_e;

   function automatic logic op_known(input logic [6:0] op);
      case (op)
         OP_LOAD, OP_I, OP_AUIPC, OP_STORE, OP_R, OP_LUI,
         OP_BRANCH, OP_JALR, OP_JAL: op_known = 1'b1;
         default:                    op_known = 1'b0;
      endcase
   endfunction

   function automatic logic op_writes_rd(input logic [6:0] op);
      case (op)
         OP_LOAD, OP_I, OP_AUIPC, OP_R, OP_LUI, OP_JALR, OP_JAL: op_writes_rd = 1'b1;
         default:                                               op_writes_rd = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering for the data port: enables, store shift, load extract/extend, misalign flag.
// Purely combinational (zero latency); no handshake of its own.
module load_store_align
   import apex_ctrl_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]                   funct3,
   input  logic                         is_store,
   input  logic [$clog2(XLEN/8)-1:0]    offset,
   input  logic [XLEN-1:0]              st_data,
   input  logic [XLEN-1:0]              rdata,
   output logic [XLEN/8-1:0]            be,
   output logic [XLEN-1:0]              wdata,
   output logic [XLEN-1:0]              ld_data,
   output logic                         misaligned
);
   localparam int NB = XLEN / 8;
   localparam int OB = $clog2(NB);

   logic [OB-1:0]   mask;
   logic [NB-1:0]   lanes;
   logic [XLEN-1:0] shifted;
   logic            bad_width;

   always_comb begin
      mask      = '0;
      lanes     = NB'(1);
      bad_width = is_store && funct3[2];
      case (funct3[1:0])
         F3_B: begin lanes = NB'(1);   mask = '0;     end
         F3_H: begin lanes = NB'(3);   mask = OB'(1); end
         F3_W: begin lanes = NB'(15);  mask = OB'(3); end
         F3_D: begin
            lanes     = NB'(255);
            mask      = OB'(7);
            bad_width = bad_width || (XLEN < 64);
         end
         default: ;
      endcase
      be         = lanes << offset;
      misaligned = bad_width || ((offset & mask) != '0);
      wdata      = st_data << {offset, 3'b000};
      shifted    = rdata >> {offset, 3'b000};
      // Size casts of a $signed operand sign-extend; plain casts zero-extend.
      case (funct3[1:0])
         F3_B:    ld_data = funct3[2] ? XLEN'(shifted[7:0])  : XLEN'($signed(shifted[7:0]));
         F3_H:    ld_data = funct3[2] ? XLEN'(shifted[15:0]) : XLEN'($signed(shifted[15:0]));
         F3_W:    ld_data = funct3[2] ? XLEN'(shifted[31:0]) : XLEN'($signed(shifted[31:0]));
         default: ld_data = shifted;
      endcase
   end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle control/commit unit: IDLE->EXEC->(MEM)->WB, done at N+2 (N+3+wait with memory).
// Accepts only in IDLE (instr_ready); MEM stalls on mem_ready until MEM_TIMEOUT, then traps.
module mc_control_unit
   import apex_ctrl_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                instr_valid,
   output logic                instr_ready,
   input  logic [6:0]          opcode,
   input  logic [2:0]          funct3,
   input  logic [4:0]          rd_addr,
   input  logic [XLEN-1:0]     rs1_input,
   input  logic [XLEN-1:0]     rs2_input,
   input  logic [XLEN-1:0]     imm,
   input  logic [XLEN-1:0]     pc_input,
   output logic [XLEN-1:0]     alu_a,
   output logic [XLEN-1:0]     alu_b,
   input  logic [XLEN-1:0]     alu_result,
   output logic                mem_req,
   output logic                mem_we,
   output logic [XLEN-1:0]     mem_addr,
   output logic [XLEN-1:0]     mem_wdata,
   output logic [XLEN/8-1:0]   mem_be,
   input  logic [XLEN-1:0]     mem_rdata,
   input  logic                mem_ready,
   output logic                rd_we,
   output logic [4:0]          rd_waddr,
   output logic [XLEN-1:0]     final_output,
   output logic [XLEN-1:0]     jump,
   output logic                j_signal,
   output logic                done,
   output logic                trap
);
   localparam int NB = XLEN / 8;
   localparam int OB = $clog2(NB);
   localparam int CW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

   state_e          state_q, state_d;
   logic [6:0]      op_q, op_d;
   logic [2:0]      f3_q, f3_d;
   logic [4:0]      rd_q, rd_d;
   logic [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d, imm_q, imm_d, pc_q, pc_d, res_q, res_d;
   logic [XLEN-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [XLEN-1:0] fo_q, fo_d, jump_q, jump_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            trap_q, trap_d, jsig_q, jsig_d;

   logic [OB-1:0]   addr_off;
   logic [XLEN-1:0] st_wdata, ld_data, pc4, target, wb_val;
   logic [NB-1:0]   be_w;
   logic            mis_w, taken, is_mem, is_store, is_jump, wb_trap;

   assign is_store = (op_q == OP_STORE);
   assign is_mem   = (op_q == OP_LOAD) || is_store;
   assign is_jump  = (op_q == OP_JAL) || (op_q == OP_JALR);
   assign pc4      = pc_q + XLEN'(4);
   // Alignment is judged on the live ALU result in EXEC and on the captured address in MEM.
   assign addr_off = (state_q == S_EXEC) ? alu_result[OB-1:0] : res_q[OB-1:0];

   load_store_align #(.XLEN(XLEN)) u_align (
      .funct3     (f3_q),
      .is_store   (is_store),
      .offset     (addr_off),
      .st_data    (rs2_q),
      .rdata      (mem_rdata),
      .be         (be_w),
      .wdata      (st_wdata),
      .ld_data    (ld_data),
      .misaligned (mis_w)
   );

   always_comb begin
      taken = 1'b0;
      case (f3_q)
         F3_BEQ:  taken = (rs1_q == rs2_q);
         F3_BNE:  taken = (rs1_q != rs2_q);
         F3_BLT:  taken = ($signed(rs1_q) <  $signed(rs2_q));
         F3_BGE:  taken = ($signed(rs1_q) >= $signed(rs2_q));
         F3_BLTU: taken = (rs1_q <  rs2_q);
         F3_BGEU: taken = (rs1_q >= rs2_q);
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      case (op_q)
         OP_BRANCH: target = taken ? (pc_q + imm_q) : pc4;
         OP_JAL:    target = pc_q + imm_q;
         OP_JALR:   target = (rs1_q + imm_q) & ~XLEN'(1);
         default:   target = pc4;
      endcase
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      f3_d    = f3_q;
      rd_d    = rd_q;
      rs1_d   = rs1_q;
      rs2_d   = rs2_q;
      imm_d   = imm_q;
      pc_d    = pc_q;
      res_d   = res_q;
      alu_a_d = alu_a_q;
      alu_b_d = alu_b_q;
      cnt_d   = cnt_q;
      trap_d  = trap_q;
      fo_d    = fo_q;
      jump_d  = jump_q;
      jsig_d  = jsig_q;
      wb_val  = res_q;
      wb_trap = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (instr_valid) begin
               state_d = S_EXEC;
               op_d    = opcode;
               f3_d    = funct3;
               rd_d    = rd_addr;
               rs1_d   = rs1_input;
               rs2_d   = rs2_input;
               imm_d   = imm;
               pc_d    = pc_input;
               case (opcode)
                  OP_R:                    begin alu_a_d = rs1_input; alu_b_d = rs2_input; end
                  OP_I, OP_LOAD, OP_STORE: begin alu_a_d = rs1_input; alu_b_d = imm;       end
                  OP_LUI:                  begin alu_a_d = '0;        alu_b_d = imm;       end
                  OP_AUIPC:                begin alu_a_d = pc_input;  alu_b_d = imm;       end
                  default:                 begin alu_a_d = '0;        alu_b_d = '0;        end
               endcase
            end
         end
         S_EXEC: begin
            res_d  = alu_result;
            wb_val = alu_result;
            if (!op_known(op_q) || (is_mem && mis_w)) begin
               state_d = S_WB;
               wb_trap = 1'b1;
            end else if (is_mem) begin
               state_d = S_MEM;
               cnt_d   = '0;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            if (mem_ready) begin
               state_d = S_WB;
               wb_val  = is_store ? res_q : ld_data;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_WB;
               wb_trap = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Writeback results are committed on entry to WB and then held until the next WB.
      if (state_d == S_WB) begin
         trap_d = wb_trap;
         fo_d   = wb_trap ? '0 : (is_jump ? pc4 : wb_val);
         jump_d = wb_trap ? pc4 : target;
         jsig_d = !wb_trap && (target != pc4);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         f3_q    <= '0;
         rd_q    <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         imm_q   <= '0;
         pc_q    <= '0;
         res_q   <= '0;
         alu_a_q <= '0;
         alu_b_q <= '0;
         cnt_q   <= '0;
         trap_q  <= 1'b0;
         fo_q    <= '0;
         jump_q  <= '0;
         jsig_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         f3_q    <= f3_d;
         rd_q    <= rd_d;
         rs1_q   <= rs1_d;
         rs2_q   <= rs2_d;
         imm_q   <= imm_d;
         pc_q    <= pc_d;
         res_q   <= res_d;
         alu_a_q <= alu_a_d;
         alu_b_q <= alu_b_d;
         cnt_q   <= cnt_d;
         trap_q  <= trap_d;
         fo_q    <= fo_d;
         jump_q  <= jump_d;
         jsig_q  <= jsig_d;
      end
   end

   assign instr_ready  = (state_q == S_IDLE);
   assign mem_req      = (state_q == S_MEM);
   assign mem_we       = mem_req && is_store;
   assign mem_addr     = mem_req ? res_q : '0;
   assign mem_be       = mem_req ? be_w : '0;
   assign mem_wdata    = mem_we ? st_wdata : '0;
   assign done         = (state_q == S_WB);
   assign trap         = done && trap_q;
   assign rd_we        = done && !trap_q && (rd_q != 5'd0) && op_writes_rd(op_q);
   assign rd_waddr     = rd_q;
   assign alu_a        = alu_a_q;
   assign alu_b        = alu_b_q;
   assign final_output = fo_q;
   assign jump         = jump_q;
   assign j_signal     = jsig_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed table-driven bench for mc_control_unit (XLEN=32, MEM_TIMEOUT=4),
// plus hand-written timeout and mid-operation reset sequences.
module tb_mc_control_unit;
   import apex_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_valid, instr_ready;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [4:0]  rd_addr;
   logic [31:0] rs1_input, rs2_input, imm, pc_input, alu_a, alu_b, alu_result;
   logic        mem_req, mem_we, mem_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;
   logic        rd_we, j_signal, done, trap;
   logic [4:0]  rd_waddr;
   logic [31:0] final_output, jump;

   mc_control_unit #(.XLEN(32), .MEM_TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .opcode(opcode), .funct3(funct3), .rd_addr(rd_addr),
      .rs1_input(rs1_input), .rs2_input(rs2_input), .imm(imm), .pc_input(pc_input),
      .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .rd_we(rd_we), .rd_waddr(rd_waddr), .final_output(final_output),
      .jump(jump), .j_signal(j_signal), .done(done), .trap(trap)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic [31:0] rs1, rs2, immv, pc, alu, rdata;
      logic        rdy;
      logic [31:0] e_a, e_b;
      int          e_cyc;
      logic        e_we;
      logic [31:0] e_fo, fo_m, e_jmp;
      logic        e_js, e_trap, e_mem;
      logic [3:0]  e_be;
      logic [31:0] e_wd, wd_m;
   } vec_t;

   localparam int NV = 20;
   vec_t vecs [NV];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input vec_t v);
      opcode     = v.op;
      funct3     = v.f3;
      rd_addr    = v.rd;
      rs1_input  = v.rs1;
      rs2_input  = v.rs2;
      imm        = v.immv;
      pc_input   = v.pc;
      alu_result = v.alu;
      mem_rdata  = v.rdata;
      mem_ready  = v.rdy;
   endtask

   task automatic run_vec(input vec_t v);
      int          cyc;
      logic        seen;
      logic [3:0]  be_s;
      logic [31:0] wd_s;
      drive(v);
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      cyc = 1;
      chk({v.name, ".alu_a"}, 64'(alu_a), 64'(v.e_a));
      chk({v.name, ".alu_b"}, 64'(alu_b), 64'(v.e_b));
      chk({v.name, ".exec_ready"}, 64'(instr_ready), 64'(1'b0));
      seen = mem_req;
      be_s = mem_be;
      wd_s = mem_wdata;
      while (!done && cyc < 20) begin
         tick();
         cyc++;
         if (mem_req) begin
            seen = 1'b1;
            be_s = mem_be;
            wd_s = mem_wdata;
         end
      end
      chk({v.name, ".done_cycle"}, 64'(cyc), 64'(v.e_cyc));
      chk({v.name, ".rd_we"}, 64'(rd_we), 64'(v.e_we));
      chk({v.name, ".trap"}, 64'(trap), 64'(v.e_trap));
      chk({v.name, ".final_output"}, 64'(final_output & v.fo_m), 64'(v.e_fo & v.fo_m));
      chk({v.name, ".jump"}, 64'(jump), 64'(v.e_jmp));
      chk({v.name, ".j_signal"}, 64'(j_signal), 64'(v.e_js));
      chk({v.name, ".mem_req_seen"}, 64'(seen), 64'(v.e_mem));
      if (v.e_mem) begin
         chk({v.name, ".mem_be"}, 64'(be_s), 64'(v.e_be));
         chk({v.name, ".mem_wdata"}, 64'(wd_s & v.wd_m), 64'(v.e_wd & v.wd_m));
      end
      tick();
      chk({v.name, ".ready_after_wb"}, 64'(instr_ready), 64'(1'b1));
      chk({v.name, ".fo_hold"}, 64'(final_output & v.fo_m), 64'(v.e_fo & v.fo_m));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t t;
      int   cnt;
      int   guard;
      //          name        op         f3    rd     rs1           rs2           imm           pc            alu           rdata         rdy   e_a           e_b           cyc we    e_fo          fo_m          e_jmp         js    trap  mem   be       e_wd          wd_m
      vecs[0]  = '{"r_add",   OP_R,      3'd0, 5'd5,  32'd13,       32'd13,       32'd0,        32'd10,       32'd26,       32'd0,        1'b1, 32'd13,       32'd13,       2, 1'b1, 32'd26,       32'hFFFFFFFF, 32'd14,       1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0};
      vecs[1]  = '{"lb",      OP_LOAD,   3'd0, 5'd7,  32'h100,      32'h0,        32'h3,        32'h40,       32'h103,      32'h80000000, 1'b1, 32'h100,      32'h3,        3, 1'b1, 32'hFFFFFF80, 32'hFFFFFFFF, 32'h44,       1'b0, 1'b0, 1'b1, 4'b1000, 32'h0,        32'h0};
      vecs[2]  = '{"lbu",     OP_LOAD,   3'd4, 5'd7,  32'h100,      32'h0,        32'h3,        32'h40,       32'h103,      32'h80000000, 1'b1, 32'h100,      32'h3,        3, 1'b1, 32'h00000080, 32'hFFFFFFFF, 32'h44,       1'b0, 1'b0, 1'b1, 4'b1000, 32'h0,        32'h0};
      vecs[3]  = '{"sh",      OP_STORE,  3'd1, 5'd3,  32'h100,      32'h0003FFFF, 32'h2,        32'h20,       32'h102,      32'h0,        1'b1, 32'h100,      32'h2,        3, 1'b0, 32'h0,        32'h0,        32'h24,       1'b0, 1'b0, 1'b1, 4'b1100, 32'hFFFF0000, 32'hFFFF0000};
      vecs[4]  = '{"sh_mis",  OP_STORE,  3'd1, 5'd3,  32'h100,      32'h0003FFFF, 32'h1,        32'h20,       32'h101,      32'h0,        1'b1, 32'h100,      32'h1,        2, 1'b0, 32'h0,        32'h0,        32'h24,       1'b0, 1'b1, 1'b0, 4'b0000, 32'h0,        32'h0};
      vecs[5]  = '{"blt",     OP_BRANCH, 3'd4, 5'd0,  32'hFFFFFFFF, 32'd1,        32'd8,        32'd10,       32'h0,        32'h0,        1'b1, 32'h0,        32'h0,        2, 1'b0, 32'h0,        32'h0,        32'd18,       1'b1, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0};
      vecs[6]  = '{"bltu",    OP_BRANCH, 3'd6, 5'd0,  32'hFFFFFFFF, 32'd1,        32'd8,        32'd10,       32'h0,        32'h0,        1'b1, 32'h0,        32'h0,        2, 1'b0, 32'h0,        32'h0,        32'd14,       1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0};
      vecs[7]  = '{"jalr",    OP_JALR,   3'd0, 5'd1,  32'd10,       32'h0,        32'd1,        32'h30,       32'h0,        32'h0,        1'b1, 32'h0,        32'h0,        2, 1'b1, 32'h34,       32'hFFFFFFFF, 32'd10,       1'b1, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0};
      vecs[8]  = '{"jal",     OP_JAL,    3'd0, 5'd1,  32'h0,        32'h0,        32'hFFFFFFF0, 32'h100,      32'h0,        32'h0,        1'b1, 32'h0,        32'h0,        2, 1'b1, 32'h104,      32'hFFFFFFFF, 32'hF0,       1'b1, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0};
      vecs[9]  = '{"lui",     OP_LUI,    3'd0, 5'd2,  32'h55,       32'h0,        32'h12345000, 32'h8,        32'h12345000, 32'h0,        1'b1, 32'h0,        32'h12345000, 2, 1'b1, 32'h12345000, 32'hFFFFFFFF, 32'hC,        1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0};
      vecs[10] = '{"auipc",   OP_AUIPC,  3'd0, 5'd4,  32'h0,        32'h0,        32'h2000,     32'h1000,     32'h3000,     32'h0,        1'b1, 32'h1000,     32'h2000,     2, 1'b1, 32'h3000,     32'hFFFFFFFF, 32'h1004,     1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0};
      vecs[11] = '{"illegal", 7'h7F,     3'd0, 5'd6,  32'h1,        32'h2,        32'h3,        32'h50,       32'h99,       32'h0,        1'b1, 32'h0,        32'h0,        2, 1'b0, 32'h0,        32'h0,        32'h54,       1'b0, 1'b1, 1'b0, 4'b0000, 32'h0,        32'h0};
      vecs[12] = '{"beq_t",   OP_BRANCH, 3'd0, 5'd0,  32'd5,        32'd5,        32'h20,       32'h0,        32'h0,        32'h0,        1'b1, 32'h0,        32'h0,        2, 1'b0, 32'h0,        32'h0,        32'h20,       1'b1, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0};
      vecs[13] = '{"bge_nt",  OP_BRANCH, 3'd5, 5'd0,  32'hFFFFFFFE, 32'd3,        32'h40,       32'h100,      32'h0,        32'h0,        1'b1, 32'h0,        32'h0,        2, 1'b0, 32'h0,        32'h0,        32'h104,      1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0};
      vecs[14] = '{"lw_mis",  OP_LOAD,   3'd2, 5'd8,  32'h104,      32'h0,        32'h2,        32'h60,       32'h106,      32'h0,        1'b1, 32'h104,      32'h2,        2, 1'b0, 32'h0,        32'h0,        32'h64,       1'b0, 1'b1, 1'b0, 4'b0000, 32'h0,        32'h0};
      vecs[15] = '{"lh",      OP_LOAD,   3'd1, 5'd9,  32'h100,      32'h0,        32'h2,        32'h70,       32'h102,      32'h80010000, 1'b1, 32'h100,      32'h2,        3, 1'b1, 32'hFFFF8001, 32'hFFFFFFFF, 32'h74,       1'b0, 1'b0, 1'b1, 4'b1100, 32'h0,        32'h0};
      vecs[16] = '{"sb",      OP_STORE,  3'd0, 5'd0,  32'h100,      32'h000000AB, 32'h1,        32'h80,       32'h101,      32'h0,        1'b1, 32'h100,      32'h1,        3, 1'b0, 32'h0,        32'h0,        32'h84,       1'b0, 1'b0, 1'b1, 4'b0010, 32'h0000AB00, 32'h0000FF00};
      vecs[17] = '{"sw",      OP_STORE,  3'd2, 5'd0,  32'h100,      32'hDEADBEEF, 32'h4,        32'h90,       32'h104,      32'h0,        1'b1, 32'h100,      32'h4,        3, 1'b0, 32'h0,        32'h0,        32'h94,       1'b0, 1'b0, 1'b1, 4'b1111, 32'hDEADBEEF, 32'hFFFFFFFF};
      vecs[18] = '{"lw_rd0",  OP_LOAD,   3'd2, 5'd0,  32'h200,      32'h0,        32'h0,        32'hA0,       32'h200,      32'h11223344, 1'b1, 32'h200,      32'h0,        3, 1'b0, 32'h11223344, 32'hFFFFFFFF, 32'hA4,       1'b0, 1'b0, 1'b1, 4'b1111, 32'h0,        32'h0};
      vecs[19] = '{"addi_wr", OP_I,      3'd0, 5'd3,  32'hFFFFFFFF, 32'h0,        32'h1,        32'hFFFFFFFC, 32'h0,        32'h0,        1'b1, 32'hFFFFFFFF, 32'h1,        2, 1'b1, 32'h0,        32'hFFFFFFFF, 32'h0,        1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0};

      rst = 1'b0;
      instr_valid = 1'b0;
      drive(vecs[0]);
      mem_ready = 1'b0;
      tick();
      tick();
      chk("reset.instr_ready", 64'(instr_ready), 64'(1'b1));
      chk("reset.mem_req", 64'(mem_req), 64'(1'b0));
      chk("reset.done", 64'(done), 64'(1'b0));
      chk("reset.rd_we", 64'(rd_we), 64'(1'b0));
      chk("reset.final_output", 64'(final_output), 64'(0));
      chk("reset.jump", 64'(jump), 64'(0));
      chk("reset.alu_a", 64'(alu_a), 64'(0));
      rst = 1'b1;
      tick();

      for (int i = 0; i < NV; i++) run_vec(vecs[i]);

      // Memory never answers: request held for exactly MEM_TIMEOUT cycles, then trap.
      t = '{"tmo", OP_LOAD, 3'd2, 5'd4, 32'h200, 32'h0, 32'h0, 32'hB0, 32'h200, 32'h0, 1'b0,
            32'h200, 32'h0, 3, 1'b0, 32'h0, 32'h0, 32'hB4, 1'b0, 1'b1, 1'b1, 4'b1111, 32'h0, 32'h0};
      drive(t);
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      cnt = 0;
      guard = 0;
      while (!done && guard < 30) begin
         tick();
         guard++;
         if (mem_req) begin
            cnt++;
            chk("tmo.mem_addr", 64'(mem_addr), 64'(32'h200));
            chk("tmo.mem_be", 64'(mem_be), 64'(4'b1111));
         end
      end
      chk("tmo.req_cycles", 64'(cnt), 64'(4));
      chk("tmo.trap", 64'(trap), 64'(1'b1));
      chk("tmo.done", 64'(done), 64'(1'b1));
      chk("tmo.rd_we", 64'(rd_we), 64'(1'b0));
      chk("tmo.mem_req_in_wb", 64'(mem_req), 64'(1'b0));
      chk("tmo.jump", 64'(jump), 64'(32'hB4));
      chk("tmo.j_signal", 64'(j_signal), 64'(1'b0));
      mem_ready = 1'b1;
      tick();
      chk("tmo.late_ready_done", 64'(done), 64'(1'b0));
      chk("tmo.late_ready_idle", 64'(instr_ready), 64'(1'b1));
      mem_ready = 1'b0;

      // Reset while in MEM; a new instruction offered during EXEC must be ignored.
      t = '{"rst", OP_LOAD, 3'd2, 5'd5, 32'h300, 32'h0, 32'h0, 32'hC0, 32'h300, 32'h0, 1'b0,
            32'h300, 32'h0, 3, 1'b0, 32'h0, 32'h0, 32'hC4, 1'b0, 1'b0, 1'b1, 4'b1111, 32'h0, 32'h0};
      drive(t);
      instr_valid = 1'b1;
      tick();
      opcode    = OP_R;
      rs1_input = 32'hBAD;
      tick();
      instr_valid = 1'b0;
      chk("rst.mem_req_before", 64'(mem_req), 64'(1'b1));
      chk("rst.alu_a_kept", 64'(alu_a), 64'(32'h300));
      #3;
      rst = 1'b0;
      #1;
      chk("rst.mem_req_drop", 64'(mem_req), 64'(1'b0));
      chk("rst.rd_we", 64'(rd_we), 64'(1'b0));
      chk("rst.done", 64'(done), 64'(1'b0));
      chk("rst.final_output", 64'(final_output), 64'(0));
      tick();
      rst = 1'b1;
      chk("rst.instr_ready", 64'(instr_ready), 64'(1'b1));
      cnt = 0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (done || rd_we || mem_req) cnt++;
      end
      chk("rst.no_activity", 64'(cnt), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
